axi_uart_tx_fifo: RTL

Parametrised UART transmit engine: successor to the fixed 8N1 transmitter behind the AXI UART TX-data register. Accepts words on a valid/ready stream from the AXI-Lite register slice and buffers them in an internal FIFO. Serialises each word with run-time selectable baud divisor, parity and stop-bit count. Drives the board-level serial output (o_serial).

---
 rtl/uart_pkg.sv | 31 +++
 rtl/sync_fifo.sv | 62 ++++++
 rtl/axi_uart_tx_fifo.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
//   tx_state_t : serialiser FSM states
//   PAR_*      : encodings of the cfg_parity input (2'b11 also means no parity)
//   clog2      : ceiling log2, usable in parameter and port-width expressions
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res++;
      v = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   clk, rst : clock and asynchronous active-high reset
//   push     : write wr_data (ignored while full, even if a pop happens too)
//   pop      : drop the head entry (ignored while empty)
//   rd_data  : current head entry, valid whenever empty is low
//   count    : entries held (0..DEPTH); full / empty are decodes of it
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    pop,
  output logic [WIDTH-1:0]        rd_data,
  output logic [clog2(DEPTH):0]   count,
  output logic                    full,
  output logic                    empty
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // NOTE: storage has no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axi_uart_tx_fifo.sv
// Buffered UART transmitter.
//   ACLK, ARESET        : clock, asynchronous active-high reset
//   enable              : allow new frames to start (a running frame always completes)
//   cfg_div             : bit period is cfg_div+1 ACLK cycles
//   cfg_parity          : 00/11 none, 01 odd, 10 even
//   cfg_stop2           : two stop bits when set
//   s_tdata/s_tvalid/s_tready : input word stream into the TX FIFO
//   o_serial            : serial line, idle high
//   busy, tx_done       : frame in progress / last cycle of a frame
//   fifo_count/empty/full : FIFO occupancy
// Configuration is sampled together with the word when a frame starts, so
// changing it mid-frame only affects the following frames.
module axi_uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  input  logic                         enable,
  input  logic [DIV_WIDTH-1:0]         cfg_div,
  input  logic [1:0]                   cfg_parity,
  input  logic                         cfg_stop2,
  input  logic [DATA_BITS-1:0]         s_tdata,
  input  logic                         s_tvalid,
  output logic                         s_tready,
  output logic                         o_serial,
  output logic                         busy,
  output logic                         tx_done,
  output logic [clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                         fifo_empty,
  output logic                         fifo_full
);

  localparam int BW = clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  tx_state_t            state;
  logic [DIV_WIDTH-1:0] baud_cnt;
  logic [BW-1:0]        bit_cnt;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] head;
  logic [DIV_WIDTH-1:0] div_q;
  logic                 par_en_q;
  logic                 par_bit_q;
  logic                 stop2_q;

  logic push;
  logic pop;
  logic bit_end;
  logic frame_end;

  // Ready is held low during reset so the source never sees a phantom slot.
  assign s_tready = !fifo_full && !ARESET;
  assign push     = s_tvalid && s_tready;

  assign bit_end   = (baud_cnt == div_q);
  assign frame_end = (state == STOP) && bit_end && (stop_cnt == stop2_q);

  // A frame starts from IDLE or directly out of the last stop cycle, which
  // gives back-to-back frames with no idle gap.
  assign pop = enable && !fifo_empty && ((state == IDLE) || frame_end);

  assign busy    = (state != IDLE);
  assign tx_done = frame_end;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (ACLK),
    .rst     (ARESET),
    .push    (push),
    .wr_data (s_tdata),
    .pop     (pop),
    .rd_data (head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state     <= IDLE;
      o_serial  <= 1'b1;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      shift     <= '0;
      div_q     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
    end else if (pop) begin
      state     <= START;
      o_serial  <= 1'b0;
      baud_cnt  <= '0;
      shift     <= head;
      div_q     <= cfg_div;
      par_en_q  <= (cfg_parity == PAR_ODD) || (cfg_parity == PAR_EVEN);
      // Even parity is the XOR of the data; odd is its inverse.
      par_bit_q <= (^head) ^ (cfg_parity == PAR_ODD);
      stop2_q   <= cfg_stop2;
    end else begin
      case (state)
        IDLE: begin
          o_serial <= 1'b1;
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= DATA;
            o_serial <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_cnt == LAST_BIT) begin
              if (par_en_q) begin
                state    <= PARITY;
                o_serial <= par_bit_q;
              end else begin
                state    <= STOP;
                stop_cnt <= 1'b0;
                o_serial <= 1'b1;
              end
            end else begin
              bit_cnt  <= bit_cnt + 1'b1;
              shift    <= shift >> 1;
              o_serial <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (bit_end) begin
            baud_cnt <= '0;
            state    <= STOP;
            stop_cnt <= 1'b0;
            o_serial <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (stop_cnt == stop2_q) begin
              state    <= IDLE;
              o_serial <= 1'b1;
            end else begin
              stop_cnt <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          o_serial <= 1'b1;
        end
      endcase
    end
  end

endmodule
